// File: rtl/lift_call_sense.sv
// Input conditioning for the lift controller: synchronises and debounces raw
// buttons/sensors/switches, latches calls until served, and derives direction flags.
module lift_call_sense #(
    parameter int FLOORS    = 4,
    parameter int DB_CYCLES = 4,
    parameter int FW        = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] btn_call,
    input  logic [FLOORS-1:0] floor_sensor,
    input  logic              door_closed_raw,
    input  logic              overload_raw,
    input  logic              svc_ack,
    output logic [FLOORS-1:0] req_pending,
    output logic [FW-1:0]     cur_floor,
    output logic              floor_valid,
    output logic              arrive_pulse,
    output logic              req_above,
    output logic              req_below,
    output logic              req_here,
    output logic              door_closed,
    output logic              overload
);

    // Bit map: [FLOORS-1:0] buttons, [2F-1:F] sensors, [2F] door, [2F+1] overload
    localparam int N  = 2*FLOORS + 2;
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [N-1:0]      raw, sync_p0, sync_p1, db, db_nxt;
    logic [CW-1:0]     cnt     [N];
    logic [CW-1:0]     cnt_nxt [N];
    logic [FLOORS-1:0] btn_q, btn_rise, clr_mask, sens_nxt;
    logic [FW-1:0]     hit_idx;
    logic              onehot;
    int                hits;

    assign raw = {overload_raw, door_closed_raw, floor_sensor, btn_call};

    // The debounced level flips on the cycle the count would reach DB_CYCLES.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            db_nxt[i]  = db[i];
            cnt_nxt[i] = '0;
            if (sync_p1[i] != db[i]) begin
                if (cnt[i] == CNT_LAST)
                    db_nxt[i] = sync_p1[i];
                else
                    cnt_nxt[i] = cnt[i] + CW'(1);
            end
        end
    end

    // Floor decode uses the next debounced vector so tracking moves on the same edge.
    assign sens_nxt = db_nxt[2*FLOORS-1:FLOORS];

    always_comb begin
        hits    = 0;
        hit_idx = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (sens_nxt[i]) begin
                hits    = hits + 1;
                hit_idx = FW'(i);
            end
        end
        onehot = (hits == 1);
    end

    assign btn_rise = db[FLOORS-1:0] & ~btn_q;
    assign clr_mask = (svc_ack && floor_valid) ?
                      ({{(FLOORS-1){1'b0}}, 1'b1} << cur_floor) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0      <= '0;
            sync_p1      <= '0;
            db           <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
            btn_q        <= '0;
            req_pending  <= '0;
            cur_floor    <= '0;
            floor_valid  <= 1'b0;
            arrive_pulse <= 1'b0;
        end else begin
            // stage p0 -> p1: two-flop synchroniser, then debounce
            sync_p0      <= raw;
            sync_p1      <= sync_p0;
            db           <= db_nxt;
            cnt          <= cnt_nxt;
            btn_q        <= db[FLOORS-1:0];
            // a new press wins over a simultaneous service clear
            req_pending  <= (req_pending & ~clr_mask) | btn_rise;
            floor_valid  <= onehot;
            if (onehot)
                cur_floor <= hit_idx;
            arrive_pulse <= onehot && (!floor_valid || hit_idx != cur_floor);
        end
    end

    always_comb begin
        req_above = 1'b0;
        req_below = 1'b0;
        for (int j = 0; j < FLOORS; j++) begin
            if (FW'(j) > cur_floor) req_above = req_above | req_pending[j];
            if (FW'(j) < cur_floor) req_below = req_below | req_pending[j];
        end
    end

    assign req_here    = req_pending[cur_floor] & floor_valid;
    assign door_closed = db[2*FLOORS];
    assign overload    = db[2*FLOORS+1];

endmodule

// File: tb/tb_lift_call_sense.sv
// Directed bench for lift_call_sense with FLOORS=4, DB_CYCLES=4.
module tb_lift_call_sense;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_call, floor_sensor, req_pending;
    logic       door_closed_raw, overload_raw, svc_ack;
    logic [1:0] cur_floor;
    logic       floor_valid, arrive_pulse, req_above, req_below, req_here;
    logic       door_closed, overload;
    int         total = 0;
    int         bad   = 0;

    lift_call_sense #(.FLOORS(4), .DB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .btn_call(btn_call), .floor_sensor(floor_sensor),
        .door_closed_raw(door_closed_raw), .overload_raw(overload_raw),
        .svc_ack(svc_ack), .req_pending(req_pending), .cur_floor(cur_floor),
        .floor_valid(floor_valid), .arrive_pulse(arrive_pulse),
        .req_above(req_above), .req_below(req_below), .req_here(req_here),
        .door_closed(door_closed), .overload(overload)
    );

    always #5 clk = ~clk;

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [13:0] outs;
        rst = 1'b1; btn_call = '0; floor_sensor = '0;
        door_closed_raw = 1'b0; overload_raw = 1'b0; svc_ack = 1'b0;
        step(2);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            outs = {req_pending, cur_floor, floor_valid, arrive_pulse, req_above,
                    req_below, req_here, door_closed, overload};
            total++;
            if (outs !== 14'd0) begin
                bad++; $display("FAIL idle_outputs cycle=%0d got=%b exp=0", c, outs);
            end
        end
    endtask

    task automatic test_glitch;
        btn_call = 4'b0100;
        step(3);
        btn_call = 4'b0000;
        step(15);
        total++;
        if (req_pending !== 4'b0000) begin
            bad++; $display("FAIL glitch_reject req got=%b exp=0000", req_pending);
        end
        btn_call = 4'b0100;
        step(6);
        total++;
        if (req_pending !== 4'b0000) begin
            bad++; $display("FAIL held_edge6 req got=%b exp=0000", req_pending);
        end
        step(1);
        total++;
        if (req_pending !== 4'b0100) begin
            bad++; $display("FAIL held_edge7 req got=%b exp=0100", req_pending);
        end
        step(3);
        btn_call = 4'b0000;
        step(15);
        total++;
        if (req_pending !== 4'b0100 || req_above !== 1'b1 || req_here !== 1'b0) begin
            bad++; $display("FAIL held_after_release req/above/here got=%b/%b/%b exp=0100/1/0",
                            req_pending, req_above, req_here);
        end
    endtask

    task automatic floor_phase(input logic [3:0] sens, input logic exp_v,
                               input logic [1:0] exp_f, input int exp_arr);
        int arr = 0;
        floor_sensor = sens;
        for (int c = 0; c < 10; c++) begin
            step(1);
            arr += int'(arrive_pulse);
        end
        total++;
        if (floor_valid !== exp_v || cur_floor !== exp_f || arr != exp_arr) begin
            bad++; $display("FAIL floor_%b valid/floor/arrivals got=%b/%0d/%0d exp=%b/%0d/%0d",
                            sens, floor_valid, cur_floor, arr, exp_v, exp_f, exp_arr);
        end
    endtask

    task automatic test_floor;
        floor_phase(4'b0001, 1'b1, 2'd0, 1);
        floor_phase(4'b0000, 1'b0, 2'd0, 0);
        floor_phase(4'b0010, 1'b1, 2'd1, 1);
        floor_phase(4'b0110, 1'b0, 2'd1, 0);
        floor_phase(4'b0010, 1'b1, 2'd1, 1);
    endtask

    task automatic test_flags;
        rst = 1'b1;
        step(2);
        floor_sensor = 4'b0010; btn_call = 4'b1010;
        rst = 1'b0;
        step(12);
        btn_call = 4'b0000;
        step(10);
        total++;
        if ({req_pending, cur_floor, floor_valid} !== {4'b1010, 2'd1, 1'b1}) begin
            bad++; $display("FAIL flags_setup req/floor/valid got=%b/%0d/%b exp=1010/1/1",
                            req_pending, cur_floor, floor_valid);
        end
        total++;
        if ({req_above, req_below, req_here} !== 3'b101) begin
            bad++; $display("FAIL flags_1010 above/below/here got=%b exp=101",
                            {req_above, req_below, req_here});
        end
        svc_ack = 1'b1; step(1); svc_ack = 1'b0;
        total++;
        if (req_pending !== 4'b1000 || {req_above, req_below, req_here} !== 3'b100) begin
            bad++; $display("FAIL svc_clear req/flags got=%b/%b exp=1000/100",
                            req_pending, {req_above, req_below, req_here});
        end
        floor_sensor = 4'b0000; step(10);
        btn_call = 4'b0010; step(10);
        btn_call = 4'b0000; step(10);
        total++;
        if (req_pending !== 4'b1010 || req_here !== 1'b0) begin
            bad++; $display("FAIL here_needs_valid req/here got=%b/%b exp=1010/0",
                            req_pending, req_here);
        end
        svc_ack = 1'b1; step(1); svc_ack = 1'b0;
        total++;
        if (req_pending !== 4'b1010) begin
            bad++; $display("FAIL ack_ignored_invalid req got=%b exp=1010", req_pending);
        end
        floor_sensor = 4'b1000; step(10);
        total++;
        if (cur_floor !== 2'd3 || {req_above, req_below, req_here} !== 3'b011) begin
            bad++; $display("FAIL flags_top floor/flags got=%0d/%b exp=3/011",
                            cur_floor, {req_above, req_below, req_here});
        end
    endtask

    task automatic test_collision;
        floor_sensor = 4'b0010; step(10);
        svc_ack = 1'b1; step(1); svc_ack = 1'b0;
        total++;
        if (req_pending !== 4'b1000) begin
            bad++; $display("FAIL collision_setup req got=%b exp=1000", req_pending);
        end
        btn_call = 4'b0010;
        step(6);
        svc_ack = 1'b1; step(1); svc_ack = 1'b0;
        total++;
        if (req_pending !== 4'b1010) begin
            bad++; $display("FAIL collision_set_wins req got=%b exp=1010", req_pending);
        end
        svc_ack = 1'b1; step(1); svc_ack = 1'b0;
        step(10);
        total++;
        if (req_pending !== 4'b1000) begin
            bad++; $display("FAIL held_no_reset req got=%b exp=1000", req_pending);
        end
        btn_call = 4'b0000;
        step(10);
    endtask

    task automatic test_mid_reset;
        btn_call = 4'b1111; door_closed_raw = 1'b1; overload_raw = 1'b1;
        step(10);
        total++;
        if ({req_pending, door_closed, overload} !== 6'b111111) begin
            bad++; $display("FAIL pre_reset req/door/ovl got=%b exp=111111",
                            {req_pending, door_closed, overload});
        end
        #3 rst = 1'b1;
        #1;
        total++;
        if ({req_pending, cur_floor, floor_valid, arrive_pulse, door_closed, overload} !== 10'd0) begin
            bad++; $display("FAIL async_reset outputs got=%b exp=0",
                            {req_pending, cur_floor, floor_valid, arrive_pulse, door_closed, overload});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        step(6);
        total++;
        if (req_pending !== 4'b0000) begin
            bad++; $display("FAIL relatch_edge6 req got=%b exp=0000", req_pending);
        end
        step(1);
        total++;
        if ({req_pending, door_closed, overload, floor_valid, cur_floor} !== {4'b1111, 3'b111, 2'd1}) begin
            bad++; $display("FAIL relatch_edge7 req/door/ovl/valid/floor got=%b exp=111111101",
                            {req_pending, door_closed, overload, floor_valid, cur_floor});
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_floor();
        test_flags();
        test_collision();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lift_call_sense.md
# lift_call_sense

Input-conditioning and call-request stage that sits directly upstream of the lift controller FSM. It synchronises and debounces raw hall/car call buttons, floor position sensors and door/overload switches. It latches each call until the controller acknowledges service at that floor, and derives the qualified direction flags (call above / below / here, arrival strobe) that the controller consumes as its condition inputs. All registers update on the rising clock edge, so outputs are stable half a cycle before the controller's falling-edge state update.

## Interface
Parameters:
- FLOORS, 4, number of landings (2..16)
- DB_CYCLES, 4, consecutive stable synchronised samples needed to accept a new input level (2..255)
- FW, $clog2(FLOORS), width of floor index

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- btn_call  in  FLOORS  raw call buttons, one per landing, active-high, asynchronous
- floor_sensor  in  FLOORS  raw landing sensors, active-high, asynchronous
- door_closed_raw  in  1  raw door-closed switch
- overload_raw  in  1  raw load-cell overload switch
- svc_ack  in  1  from controller: call at current floor is being served (level, sampled every cycle)
- req_pending  out  FLOORS  latched outstanding calls
- cur_floor  out  FW  last valid landing index
- floor_valid  out  1  exactly one debounced floor sensor asserted
- arrive_pulse  out  1  one-cycle strobe on arrival at a landing
- req_above / req_below / req_here  out  1 each  qualified direction flags
- door_closed  out  1  debounced door switch
- overload  out  1  debounced overload switch

## Operation
- Every raw input (FLOORS buttons, FLOORS sensors, door, overload) goes through its own 2-flop synchroniser and debounce counter.
- Debounce: when sync output ≠ debounced value, the counter increments; otherwise it clears to 0. The debounced value flips on the cycle the counter would reach DB_CYCLES, and the counter then clears. A pulse shorter than DB_CYCLES synchronised cycles is rejected.
- Call latch: a debounced rising edge on button i sets req_pending[i] on the next edge. A held button does not re-set the bit after it is cleared; a new press (release then press) is required.
- Service clear: svc_ack=1 with floor_valid=1 clears req_pending[cur_floor]. With floor_valid=0, svc_ack is ignored.
- Simultaneous set and clear on the same bit: set wins, and the bit stays 1.
- Floor tracking:
  - Debounced sensor vector one-hot: cur_floor takes its index and floor_valid=1.
  - Vector zero or multi-hot: floor_valid=0 and cur_floor holds its last value.
- arrive_pulse=1 for exactly one cycle when floor_valid goes 0→1, or when cur_floor changes while floor_valid stays 1.
- Direction flags are combinational from registered req_pending and cur_floor:
  - req_above = OR of req_pending[j] for j>cur_floor
  - req_below = OR of req_pending[j] for j<cur_floor
  - req_here = req_pending[cur_floor] AND floor_valid
- Out-of-range cur_floor cannot occur (FW sized from FLOORS).

## Timing
- Reset values: req_pending=0, cur_floor=0, floor_valid=0, arrive_pulse=0, door_closed=0, overload=0. All synchroniser and counter registers are cleared, so the flags evaluate to 0.
- Debounced output latency: raw level stable before rising edge n is reflected in the debounced output after edge n+1+DB_CYCLES.
- req_pending latency: set one edge after the debounced rise, i.e. after edge n+2+DB_CYCLES. Clear is visible the edge after svc_ack is sampled.
- floor_valid, cur_floor and arrive_pulse update on the same edge as the debounced sensor vector.
- Reset mid-operation discards all latched calls and in-progress debounce counts immediately. Inputs already high at reset release are accepted as new edges after debounce latency, so a held button produces a call.

## Test plan
- Reset then idle: with all inputs 0 for 20 cycles, all outputs stay 0.
- Glitch reject (DB_CYCLES=4): btn_call[2] high for 3 cycles -> req_pending stays 0000. Held high for 10 cycles -> req_pending=0100 after edge 7 from assertion, and stays set after release.
- Floor tracking: floor_sensor 0001→0000→0010 with each level stable for 10 cycles -> floor_valid drops, then cur_floor=1 and floor_valid=1 with one arrive_pulse. Sensor 0110 -> floor_valid=0 and cur_floor holds 1.
- Direction flags: req_pending=1010 and cur_floor=1 -> req_above=1, req_below=0, req_here=1. svc_ack pulse -> req_pending=1000 and req_here=0.
- Collision: a new press at floor 1 debounced on the same cycle as svc_ack at cur_floor=1 -> req_pending[1] remains 1.
- Mid-run reset: with req_pending=1111, assert rst asynchronously between edges -> outputs 0 immediately. Buttons still held -> calls re-latch 3+DB_CYCLES edges after release of rst.
